keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Synthesizable stand-in for the 4x4 matrix keypad: the responder end of the
//  row/col scan interface. It watches the one-hot row drive from the scanner
//  FSM and returns the column a real switch would close. Contact bounce is
//  programmable. Keypresses are queued over a valid/ready command port.
//  Used for board self-test and for closed-loop benches of scanner,
//  synchronizer, debouncer and top.
// PARAMETERS
//  BOUNCE_PULSES  2   bounce pulses on press and on release; 0 = clean contact
//  BOUNCE_CYCLES  3   cycles per bounce phase (B); must be >=1
//  HOLD_W         16  width of the hold-duration field
// PORTS
//  clk        in   1       system clock; all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  cmd_valid  in   1       press command offered
//  cmd_ready  out  1       emulator can accept a command
//  cmd_key    in   4       {row_idx[3:2], col_idx[1:0]} of the key to press
//  cmd_hold   in   HOLD_W  stable-closed cycles H; 0 is treated as 1
//  row        in   4       scanner row drive, active-high, nominally one-hot
//  col        out  4       column return, active-high
//  busy       out  1       press in progress (state != IDLE)
//  done       out  1       one-cycle pulse when the press sequence completes
// BEHAVIOUR
//  - Reset (reset=0) asynchronously forces these values:
//    state=IDLE, contact=0, col=0, done=0, busy=0, cmd_ready=1.
//    The counters and latched key are also cleared.
//    Reset mid-press abandons the press immediately. No done pulse is issued.
//  - Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready.
//    cmd_ready = (state==IDLE). cmd_valid while busy is ignored; nothing is queued.
//    On accept, cmd_key and cmd_hold are latched; later input changes are ignored.
//  - Column output is combinational from the registered contact:
//    col[c] = contact & row[key_row] & (c==key_col).
//    Extra row bits high do not matter; only row[key_row] is examined.
//    With row=0, col=0.
//  - FSM, with accept edge t0:
//    IDLE -> PRESS_BOUNCE on accept.
//      If BOUNCE_PULSES==0, go straight to HELD instead.
//    PRESS_BOUNCE: BOUNCE_PULSES repetitions of (contact=1 for B, contact=0 for B).
//      The first closed cycle is t0+1. Then -> HELD.
//    HELD: contact=1 for exactly max(H,1) cycles.
//      Then -> RELEASE_BOUNCE, or IDLE if BOUNCE_PULSES==0.
//    RELEASE_BOUNCE: BOUNCE_PULSES repetitions of (contact=0 for B, contact=1 for B).
//      Then -> IDLE with contact=0.
//    done=1 for the first IDLE cycle only, at t0+1+4*BOUNCE_PULSES*B+max(H,1).
//      cmd_ready is also 1 in that cycle.
//      A new command accepted then starts at the next edge; back-to-back presses work.
//  - Phase and hold counters count down to 0; there is no wrap. H=2^HOLD_W-1
//    is legal.
//  - Total closed cycles on press = BOUNCE_PULSES*B + max(H,1)
//    + BOUNCE_PULSES*B (release bounce).
// TESTING
//  1 Reset: reset=0 mid-HELD with row=4'b0001, key 4'h0
//    -> col=0 and cmd_ready=1 in the same cycle; no done pulse.
//  2 Clean press: BOUNCE_PULSES=0, key 4'h6 (row1,col2), H=5, row held 4'b0010
//    -> col=4'b0100 for cycles t0+1..t0+5; col=0 after; done at t0+6.
//  3 Row gating: same command, row cycling 0001,0010,0100,1000 each cycle
//    -> col=4'b0100 only in row=0010 cycles; otherwise 0.
//  4 Bounce: defaults (2,3), key 4'h0, H=10, row=4'b0001
//    -> col sequence 1x3,0x3,1x3,0x3,1x10,0x3,1x3,0x3,1x3, then 0.
//       done at t0+35.
//  5 Handshake: cmd_valid held through a press with a second key 4'hF
//    -> accepted only in the done cycle; second press begins next edge.
//  6 Loopback: drive top's async_col from col, fed by its own row
//    -> after debounce the display shows the pressed key digit.
//       Bounce produces exactly one registered keypress.

Source files
------------

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 matrix keypad: returns the column a closed switch would
// drive for the scanned row, with programmable contact bounce on press and release.
module keypad_emulator #(
  parameter int BOUNCE_PULSES = 2,
  parameter int BOUNCE_CYCLES = 3,
  parameter int HOLD_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(BOUNCE_CYCLES + 1);
  localparam int CW = (HOLD_W > BW) ? HOLD_W : BW;
  localparam int PW = $clog2(BOUNCE_PULSES + 2);
  localparam logic [CW-1:0] B_LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'((BOUNCE_PULSES > 0) ? BOUNCE_PULSES - 1 : 0);
  localparam bit CLEAN = (BOUNCE_PULSES == 0);

  typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE} state_t;

  state_t            state, state_n;
  logic              contact, contact_n;
  logic              done_n;
  logic              phase, phase_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [PW-1:0]     pulse, pulse_n;
  logic [3:0]        key, key_n;
  logic [HOLD_W-1:0] hold, hold_n;

  // Hold of 0 behaves as 1, so the terminal count is h-1 clamped at 0.
  function automatic logic [CW-1:0] hold_last(input logic [HOLD_W-1:0] h);
    return (h == '0) ? '0 : CW'(h - HOLD_W'(1));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      contact <= 1'b0;
      done    <= 1'b0;
      phase   <= 1'b0;
      cnt     <= '0;
      pulse   <= '0;
      key     <= '0;
      hold    <= '0;
    end else begin
      state   <= state_n;
      contact <= contact_n;
      done    <= done_n;
      phase   <= phase_n;
      cnt     <= cnt_n;
      pulse   <= pulse_n;
      key     <= key_n;
      hold    <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    contact_n = contact;
    done_n    = 1'b0;
    phase_n   = phase;
    cnt_n     = cnt;
    pulse_n   = pulse;
    key_n     = key;
    hold_n    = hold;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          key_n     = cmd_key;
          hold_n    = cmd_hold;
          contact_n = 1'b1;
          phase_n   = 1'b0;
          pulse_n   = P_LAST;
          if (CLEAN) begin
            state_n = HELD;
            cnt_n   = hold_last(cmd_hold);
          end else begin
            state_n = PRESS_BOUNCE;
            cnt_n   = B_LAST;
          end
        end
      end
      PRESS_BOUNCE: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          cnt_n = B_LAST;
          if (!phase) begin
            phase_n   = 1'b1;
            contact_n = 1'b0;
          end else if (pulse != '0) begin
            pulse_n   = pulse - PW'(1);
            phase_n   = 1'b0;
            contact_n = 1'b1;
          end else begin
            state_n   = HELD;
            cnt_n     = hold_last(hold);
            contact_n = 1'b1;
            phase_n   = 1'b0;
          end
        end
      end
      HELD: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          contact_n = 1'b0;
          if (CLEAN) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = RELEASE_BOUNCE;
            cnt_n   = B_LAST;
            phase_n = 1'b0;
            pulse_n = P_LAST;
          end
        end
      end
      RELEASE_BOUNCE: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          cnt_n = B_LAST;
          // phase 0 is the open half, phase 1 the closed half of each bounce
          if (!phase) begin
            phase_n   = 1'b1;
            contact_n = 1'b1;
          end else if (pulse != '0) begin
            pulse_n   = pulse - PW'(1);
            phase_n   = 1'b0;
            contact_n = 1'b0;
          end else begin
            state_n   = IDLE;
            contact_n = 1'b0;
            done_n    = 1'b1;
            cnt_n     = '0;
            phase_n   = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    col = '0;
    if (contact && row[key[3:2]]) col[key[1:0]] = 1'b1;
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a clean-contact and a bouncing instance, checked
// cycle by cycle against a closed-form contact model through a scoreboard queue.
module tb_keypad_emulator;

  localparam int B = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  key = '0;
  logic [15:0] hold = '0;
  logic [3:0]  row = '0;
  logic        sel = 1'b0;

  logic       c_valid, c_ready, c_busy, c_done;
  logic [3:0] c_col;
  logic       b_valid, b_ready, b_busy, b_done;
  logic [3:0] b_col;

  assign c_valid = valid & ~sel;
  assign b_valid = valid & sel;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_PULSES(0), .BOUNCE_CYCLES(B), .HOLD_W(16)) dut_clean (
    .clk(clk), .reset(reset), .cmd_valid(c_valid), .cmd_ready(c_ready),
    .cmd_key(key), .cmd_hold(hold), .row(row), .col(c_col),
    .busy(c_busy), .done(c_done));

  keypad_emulator #(.BOUNCE_PULSES(2), .BOUNCE_CYCLES(B), .HOLD_W(16)) dut_bounce (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_key(key), .cmd_hold(hold), .row(row), .col(b_col),
    .busy(b_busy), .done(b_done));

  int n_tests = 0;
  int n_fail  = 0;
  string test_name = "reset";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s at %0t: got %0h expected %0h", test_name, tag, $time, got, exp);
    end
  endtask

  // behavioural model of the selected instance
  bit         m_active = 0;
  bit         m_done = 0;
  int         m_k = 0;
  int         m_n = 0;
  int         m_hm = 0;
  logic [3:0] m_key = '0;

  function automatic bit contact_at(input int k, input int bp, input int hm);
    int pb = 2 * bp * B;
    int k2, k3;
    if (k <= pb) return ((k - 1) % (2 * B)) < B;
    k2 = k - pb;
    if (k2 <= hm) return 1'b1;
    k3 = k2 - hm;
    if (k3 <= pb) return ((k3 - 1) % (2 * B)) >= B;
    return 1'b0;
  endfunction

  task automatic model_step();
    int bp = sel ? 2 : 0;
    bit acc = valid && !m_active && reset;
    m_done = m_active && (m_k == m_n);
    if (acc) begin
      m_active = 1;
      m_k = 1;
      m_key = key;
      m_hm = (hold == 0) ? 1 : int'(hold);
      m_n = 4 * bp * B + m_hm;
    end else if (m_active) begin
      if (m_k == m_n) m_active = 0;
      else m_k++;
    end
  endtask

  typedef struct {
    logic [3:0] col;
    logic       done;
    logic       ready;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model_out(input logic [3:0] r);
    exp_t e;
    int bp = sel ? 2 : 0;
    logic [3:0] rr = r;
    bit c = m_active && contact_at(m_k, bp, m_hm);
    e.col   = (c && rr[m_key[3:2]]) ? (4'b0001 << m_key[1:0]) : 4'b0000;
    e.done  = m_done;
    e.ready = !m_active;
    e.busy  = m_active;
    return e;
  endfunction

  // one clock cycle: drive row, queue expectation, compare at negedge, advance model
  task automatic cyc(input logic [3:0] r);
    exp_t e;
    row = r;
    sb.push_back(model_out(r));
    @(negedge clk);
    e = sb.pop_front();
    chk("col",   32'(sel ? b_col : c_col),     32'(e.col));
    chk("done",  32'(sel ? b_done : c_done),   32'(e.done));
    chk("ready", 32'(sel ? b_ready : c_ready), 32'(e.ready));
    chk("busy",  32'(sel ? b_busy : c_busy),   32'(e.busy));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [3:0] k, input int h, input logic [3:0] r);
    valid = 1'b1;
    key = k;
    hold = 16'(h);
    cyc(r);
    valid = 1'b0;
  endtask

  initial begin
    logic [3:0] rr;
    #2;
    repeat (2) cyc(4'b0000);
    reset = 1'b1;
    repeat (2) cyc(4'b0000);

    test_name = "clean";
    sel = 1'b0;
    send(4'h6, 5, 4'b0010);
    repeat (8) cyc(4'b0010);

    test_name = "row_gate";
    send(4'h6, 5, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      rr = 4'b0001 << (i % 4);
      cyc(rr);
    end

    test_name = "hold0";
    send(4'h6, 0, 4'b0010);
    repeat (3) cyc(4'b0010);

    test_name = "bounce";
    sel = 1'b1;
    send(4'h0, 10, 4'b0001);
    repeat (38) cyc(4'b0001);

    test_name = "multirow";
    send(4'hB, 1, 4'b1111);
    repeat (28) cyc(4'b1111);

    test_name = "row_zero";
    send(4'hB, 2, 4'b0000);
    repeat (30) cyc(4'b0000);

    test_name = "handshake";
    valid = 1'b1;
    key = 4'h0;
    hold = 16'd4;
    cyc(4'b1001);
    key = 4'hF;
    hold = 16'd3;
    repeat (29) cyc(4'b1001);
    valid = 1'b0;
    repeat (30) cyc(4'b1001);

    test_name = "reset_mid";
    send(4'h0, 10, 4'b0001);
    repeat (15) cyc(4'b0001);
    reset = 1'b0;
    #1;
    chk("col",   32'(b_col),   32'd0);
    chk("ready", 32'(b_ready), 32'd1);
    chk("busy",  32'(b_busy),  32'd0);
    chk("done",  32'(b_done),  32'd0);
    m_active = 0;
    m_done = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    repeat (4) cyc(4'b0001);

    test_name = "after_reset";
    send(4'h5, 2, 4'b0010);
    repeat (30) cyc(4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
